pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
Parametrised, pipelined ripple-carry adder/subtractor, the successor to the team's fixed 4-bit gate-level ripple adder. The WIDTH-bit operation splits into STAGES equal slices; each slice is a ripple chain of full adders, with the inter-slice carry registered. A valid/ready handshake on both sides gives one result per cycle at full throughput, with backpressure. It sits in datapaths that need wide adds at clock rates a single ripple chain cannot meet.

Parameters:
WIDTH, 16, operand/result width in bits; must be >= 1.
STAGES, 4, pipeline stages (slices); WIDTH % STAGES must be 0, else an elaboration error. STAGES = 1 is legal.

Ports:
clk  input  1  sole clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand set on a, b, cin, sub is valid.
in_ready  output  1  block can accept an operand set this cycle.
a  input  WIDTH  operand A (unsigned or two's complement).
b  input  WIDTH  operand B.
cin  input  1  carry-in for add mode; ignored when sub=1.
sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1.
out_valid  output  1  result on sum/cout/ovf is valid.
out_ready  input  1  downstream accepts the result this cycle.
sum  output  WIDTH  result bits.
cout  output  1  carry-out of the MSB. In sub mode, 1 means no borrow.
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: every stage valid bit = 0, out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 once out_valid=0.
- Global advance enable: adv = !out_valid || out_ready. The port in_ready = adv (combinational).
- Accept: an operand set is accepted on a rising edge where in_valid && in_ready.
- On adv, all stages shift by one. A bubble (in_valid=0) enters as an invalid stage. Invalid stages also advance, so bubbles collapse only through output consumption.
- On !adv, every stage register holds. sum, cout, ovf and out_valid stay stable until the transfer completes.
- Slice k (0 = LSBs) covers bits [k*W/S +: W/S] and is computed in stage k.
  - Stage 0 carry-in = sub ? 1 : cin.
  - Stage k>0 carry-in = the registered carry-out of slice k-1 from the same transaction.
- Operand skew: upper slices of a and b (b already inverted if sub=1) are delayed through per-stage registers. Each slice meets its own carry in the same stage.
- Completed lower result slices are carried forward in de-skew registers, so all of sum is presented together.
- Latency: an operand set accepted at edge N appears with out_valid=1 after edge N+STAGES, with no stalls in between. Each stall cycle adds one cycle.
- Throughput: one result per cycle while out_ready=1.
- Results emerge in acceptance order; none are lost or duplicated.
- Width rules:
  - Result = (a + (sub ? ~b : b) + c0) mod 2^WIDTH.
  - cout = bit WIDTH of that sum.
  - ovf is computed in the final stage from the MSB full adder's carry-in and carry-out.
- Simultaneous events: with the pipe full, out_valid=1 and out_ready=1, a new input is accepted on the same edge the output retires (full rate, no bubble).
- A reset mid-operation discards all in-flight transactions. After rst_n rises, the first out_valid corresponds only to an operand accepted after release.
- Each slice is built as a chain of full-adder cells (sum = a^b^c; carry = ab | c(a^b)), so gate-level equivalence against the single-stage chain is checkable.

Test Plan:
(All with WIDTH=16, STAGES=4 unless noted.)
- Basic add, no stalls:
  - a=0x00FF, b=0x0001, cin=0, sub=0 -> out_valid high exactly 4 cycles after accept; sum=0x0100, cout=0, ovf=0.
  - a=0x0000, b=0x0000, cin=1 -> sum=0x0001.
- Carry across all slices and overflow:
  - 0xFFFF+0x0001 -> sum=0x0000, cout=1, ovf=0.
  - 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract:
  - 0x0005-0x0007 -> sum=0xFFFE, cout=0, ovf=0.
  - 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
  - 0x0009-0x0009 with cin=1 -> sum=0x0000, cout=1 (cin ignored).
- Streaming: 8 back-to-back random add/sub sets with out_ready=1 -> 8 correct results on 8 consecutive cycles, in order, starting at cycle 4. Repeat with WIDTH=8, STAGES=1 (latency 1) and WIDTH=32, STAGES=8.
- Backpressure: fill the pipe, drop out_ready for 3 cycles.
  - in_ready=0 during the stall; sum/cout/ovf/out_valid held stable.
  - After release, all results arrive in order, none lost or duplicated.
  - Random in_valid/out_ready for 1000 cycles matches the reference model.
- Reset: assert rst_n=0 asynchronously mid-stream with 3 transactions in flight.
  - out_valid and sum go to 0 without waiting for a clock edge.
  - After release, no stale result appears; the first out_valid comes 4 cycles after the first new accept.

Source files
------------

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The master drives operands and consumes results; the slave is the adder.
interface pipelined_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES slices,
// one full-adder ripple slice per stage with the inter-slice carry registered.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  pipelined_adder_if.slave bus
);
  localparam int SW = (STAGES >= 1) ? WIDTH / STAGES : 1;

  if (WIDTH < 1 || STAGES < 1 || (STAGES >= 1 && (WIDTH % STAGES) != 0)) begin : g_param_check
    $error("pipelined_adder: WIDTH must be >= 1 and an exact multiple of STAGES");
  end

  // Index 0 is the capture register; index k+1 holds the result of slice k.
  logic [WIDTH-1:0] a_reg   [STAGES];
  logic [WIDTH-1:0] b_reg   [STAGES];
  logic [WIDTH-1:0] res_reg [STAGES+1];
  logic             c_reg   [STAGES+1];
  logic             v_reg   [STAGES+1];
  logic             ovf_reg;

  logic [WIDTH-1:0] res_next   [STAGES];
  logic             carry_next [STAGES];
  logic             msb_cin;
  logic             adv;

  assign adv           = !v_reg[STAGES] || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v_reg[STAGES];
  assign bus.sum       = res_reg[STAGES];
  assign bus.cout      = c_reg[STAGES];
  assign bus.ovf       = ovf_reg;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [SW:0]      chain;
    logic [SW-1:0]    slice_sum;
    logic [WIDTH-1:0] merged;

    assign chain[0] = c_reg[gi];

    for (genvar gj = 0; gj < SW; gj++) begin : g_bit
      logic x;
      logic y;
      assign x              = a_reg[gi][gi*SW + gj];
      assign y              = b_reg[gi][gi*SW + gj];
      assign slice_sum[gj]  = x ^ y ^ chain[gj];
      assign chain[gj+1]    = (x & y) | (chain[gj] & (x ^ y));
    end

    // Lower slices ride along so the whole sum leaves the last stage together.
    always_comb begin
      merged              = res_reg[gi];
      merged[gi*SW +: SW] = slice_sum;
    end

    assign res_next[gi]   = merged;
    assign carry_next[gi] = chain[SW];

    if (gi == STAGES - 1) begin : g_msb
      assign msb_cin = chain[SW-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_reg[k] <= '0;
        b_reg[k] <= '0;
      end
      for (int k = 0; k <= STAGES; k++) begin
        res_reg[k] <= '0;
        c_reg[k]   <= 1'b0;
        v_reg[k]   <= 1'b0;
      end
      ovf_reg <= 1'b0;
    end else if (adv) begin
      // Subtract is a + ~b + 1, so the carry-in is forced high and cin ignored.
      a_reg[0]   <= bus.a;
      b_reg[0]   <= bus.sub ? ~bus.b : bus.b;
      c_reg[0]   <= bus.sub | bus.cin;
      v_reg[0]   <= bus.in_valid;
      res_reg[0] <= '0;
      for (int k = 0; k < STAGES; k++) begin
        res_reg[k+1] <= res_next[k];
        c_reg[k+1]   <= carry_next[k];
        v_reg[k+1]   <= v_reg[k];
      end
      for (int k = 1; k < STAGES; k++) begin
        a_reg[k] <= a_reg[k-1];
        b_reg[k] <= b_reg[k-1];
      end
      ovf_reg <= msb_cin ^ carry_next[STAGES-1];
    end
  end
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and scoreboard checks for pipelined_adder at 16/4, 8/1 and 32/8.
`timescale 1ns/1ps
module tb_pipelined_adder;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(16)) m ();
  pipelined_adder_if #(.WIDTH(8))  n ();
  pipelined_adder_if #(.WIDTH(32)) w ();

  pipelined_adder #(.WIDTH(16), .STAGES(4)) dut   (.clk(clk), .rst_n(rst_n), .bus(m));
  pipelined_adder #(.WIDTH(8),  .STAGES(1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(n));
  pipelined_adder #(.WIDTH(32), .STAGES(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(w));

  // Reference: {ovf, cout, sum} from a plain wide add and operand-sign overflow rule.
  function automatic logic [17:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [15:0] bb;
    logic [16:0] s;
    bb = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
    return {(a[15] == bb[15]) && (s[15] != a[15]), s[16], s[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (m.out_valid !== 1'b0 || m.sum !== 16'h0000 || m.cout !== 1'b0 || m.ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b sum=%h cout=%b ovf=%b exp 0/0000/0/0",
               m.out_valid, m.sum, m.cout, m.ovf);
    end
    checks++;
    if (m.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", m.in_ready);
    end
    checks++;
    if (n.out_valid !== 1'b0 || w.out_valid !== 1'b0 || n.sum !== 8'h00 || w.sum !== 32'h0) begin
      failures++;
      $display("FAIL reset_aux got v8=%b v32=%b s8=%h s32=%h exp all 0",
               n.out_valid, w.out_valid, n.sum, w.sum);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_add();
    m.a = 16'h00FF; m.b = 16'h0001; m.cin = 1'b0; m.sub = 1'b0;
    m.in_valid = 1'b1; m.out_ready = 1'b1;
    #1;
    checks++;
    if (m.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_in_ready got=%b exp=1", m.in_ready);
    end
    tick();
    m.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (m.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL basic_early_valid cycle=%0d got=%b exp=0", c, m.out_valid);
      end
      tick();
    end
    checks++;
    if (m.out_valid !== 1'b1 || m.sum !== 16'h0100 || m.cout !== 1'b0 || m.ovf !== 1'b0) begin
      failures++;
      $display("FAIL basic_result got valid=%b sum=%h cout=%b ovf=%b exp 1/0100/0/0",
               m.out_valid, m.sum, m.cout, m.ovf);
    end
    $display("basic a=00ff b=0001 sum=%h cout=%b ovf=%b", m.sum, m.cout, m.ovf);
    tick();
    checks++;
    if (m.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_duplicate got valid=%b exp=0", m.out_valid);
    end
  endtask

  task automatic test_add_sub_stream();
    logic [15:0] ta  [6] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0009};
    logic [15:0] tbv [6] = '{16'h0000, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0009};
    logic [15:0] es  [6] = '{16'h0001, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h0000};
    logic [5:0]  tc  = 6'b100001;
    logic [5:0]  ts  = 6'b111000;
    logic [5:0]  ec  = 6'b110010;
    logic [5:0]  eo  = 6'b010100;
    int got = 0;
    m.out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      m.in_valid = (c < 6);
      if (c < 6) begin
        m.a = ta[c]; m.b = tbv[c]; m.cin = tc[c]; m.sub = ts[c];
      end
      tick();
      if (m.out_valid === 1'b1) begin
        checks++;
        if (got >= 6) begin
          failures++;
          $display("FAIL stream16_extra cycle=%0d got sum=%h exp no result", c, m.sum);
        end else begin
          if (c != got + 4 || m.sum !== es[got] || m.cout !== ec[got] || m.ovf !== eo[got]) begin
            failures++;
            $display("FAIL stream16_result idx=%0d cycle=%0d got sum=%h cout=%b ovf=%b exp cycle=%0d sum=%h cout=%b ovf=%b",
                     got, c, m.sum, m.cout, m.ovf, got + 4, es[got], ec[got], eo[got]);
          end
          $display("stream16 #%0d a=%h b=%h sub=%b sum=%h cout=%b ovf=%b",
                   got, ta[got], tbv[got], ts[got], m.sum, m.cout, m.ovf);
          got++;
        end
      end
    end
    checks++;
    if (got != 6) begin
      failures++;
      $display("FAIL stream16_count got=%0d exp=6", got);
    end
  endtask

  task automatic test_stream_w8();
    logic [7:0] ta  [5] = '{8'h12, 8'hF0, 8'h80, 8'h10, 8'h7F};
    logic [7:0] tbv [5] = '{8'h34, 8'h20, 8'h01, 8'h20, 8'h7F};
    logic [7:0] es  [5] = '{8'h46, 8'h11, 8'h7F, 8'hF0, 8'hFF};
    logic [4:0] tc  = 5'b10010;
    logic [4:0] ts  = 5'b01100;
    logic [4:0] ec  = 5'b00110;
    logic [4:0] eo  = 5'b10100;
    int got = 0;
    n.out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      n.in_valid = (c < 5);
      if (c < 5) begin
        n.a = ta[c]; n.b = tbv[c]; n.cin = tc[c]; n.sub = ts[c];
      end
      tick();
      if (n.out_valid === 1'b1) begin
        checks++;
        if (got >= 5) begin
          failures++;
          $display("FAIL stream8_extra cycle=%0d got sum=%h exp no result", c, n.sum);
        end else begin
          if (c != got + 1 || n.sum !== es[got] || n.cout !== ec[got] || n.ovf !== eo[got]) begin
            failures++;
            $display("FAIL stream8_result idx=%0d cycle=%0d got sum=%h cout=%b ovf=%b exp cycle=%0d sum=%h cout=%b ovf=%b",
                     got, c, n.sum, n.cout, n.ovf, got + 1, es[got], ec[got], eo[got]);
          end
          $display("stream8 #%0d a=%h b=%h sub=%b sum=%h cout=%b ovf=%b",
                   got, ta[got], tbv[got], ts[got], n.sum, n.cout, n.ovf);
          got++;
        end
      end
    end
    checks++;
    if (got != 5) begin
      failures++;
      $display("FAIL stream8_count got=%0d exp=5", got);
    end
  endtask

  task automatic test_stream_w32();
    logic [31:0] ta  [5] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h12345678, 32'h00000000, 32'h0F0F0F0F};
    logic [31:0] tbv [5] = '{32'h00000001, 32'h00000001, 32'h11111111, 32'h00000001, 32'hF0F0F0F0};
    logic [31:0] es  [5] = '{32'h00000000, 32'h80000000, 32'h23456789, 32'hFFFFFFFF, 32'h00000000};
    logic [4:0]  tc  = 5'b10000;
    logic [4:0]  ts  = 5'b01000;
    logic [4:0]  ec  = 5'b10001;
    logic [4:0]  eo  = 5'b00010;
    int got = 0;
    w.out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      w.in_valid = (c < 5);
      if (c < 5) begin
        w.a = ta[c]; w.b = tbv[c]; w.cin = tc[c]; w.sub = ts[c];
      end
      tick();
      if (w.out_valid === 1'b1) begin
        checks++;
        if (got >= 5) begin
          failures++;
          $display("FAIL stream32_extra cycle=%0d got sum=%h exp no result", c, w.sum);
        end else begin
          if (c != got + 8 || w.sum !== es[got] || w.cout !== ec[got] || w.ovf !== eo[got]) begin
            failures++;
            $display("FAIL stream32_result idx=%0d cycle=%0d got sum=%h cout=%b ovf=%b exp cycle=%0d sum=%h cout=%b ovf=%b",
                     got, c, w.sum, w.cout, w.ovf, got + 8, es[got], ec[got], eo[got]);
          end
          $display("stream32 #%0d a=%h b=%h sub=%b sum=%h cout=%b ovf=%b",
                   got, ta[got], tbv[got], ts[got], w.sum, w.cout, w.ovf);
          got++;
        end
      end
    end
    checks++;
    if (got != 5) begin
      failures++;
      $display("FAIL stream32_count got=%0d exp=5", got);
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] q [$];
    logic [17:0] exp_v;
    logic [17:0] snap;
    int acc = 0;
    int ret = 0;
    snap = '0;
    for (int c = 0; c < 1040; c++) begin
      if (c < 20) begin
        m.in_valid  = (c < 12);
        m.out_ready = !(c >= 6 && c <= 8);
        m.a   = 16'h0F00 + 16'(c) * 16'h0111;
        m.b   = 16'h00F3 ^ 16'(c);
        m.sub = c[0];
        m.cin = c[1];
      end else if (c < 1020) begin
        m.in_valid  = 1'($urandom_range(0, 1));
        m.out_ready = ($urandom_range(0, 3) != 0);
        m.a   = 16'($urandom);
        m.b   = 16'($urandom);
        m.sub = 1'($urandom_range(0, 1));
        m.cin = 1'($urandom_range(0, 1));
      end else begin
        m.in_valid  = 1'b0;
        m.out_ready = 1'b1;
      end
      #1;
      if (c >= 6 && c <= 8) begin
        checks++;
        if (m.in_ready !== 1'b0 || m.out_valid !== 1'b1) begin
          failures++;
          $display("FAIL bp_stall_ready cycle=%0d got in_ready=%b out_valid=%b exp 0/1",
                   c, m.in_ready, m.out_valid);
        end
        if (c == 6) begin
          snap = {m.ovf, m.cout, m.sum};
        end else begin
          checks++;
          if ({m.ovf, m.cout, m.sum} !== snap) begin
            failures++;
            $display("FAIL bp_stall_hold cycle=%0d got=%h exp=%h", c, {m.ovf, m.cout, m.sum}, snap);
          end
        end
      end
      if (m.out_valid === 1'b1 && m.out_ready === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL bp_extra cycle=%0d got sum=%h exp no result", c, m.sum);
        end else begin
          exp_v = q.pop_front();
          if ({m.ovf, m.cout, m.sum} !== exp_v) begin
            failures++;
            $display("FAIL bp_result idx=%0d got ovf=%b cout=%b sum=%h exp ovf=%b cout=%b sum=%h",
                     ret, m.ovf, m.cout, m.sum, exp_v[17], exp_v[16], exp_v[15:0]);
          end
          $display("bp #%0d sum=%h cout=%b ovf=%b", ret, m.sum, m.cout, m.ovf);
          ret++;
        end
      end
      if (m.in_valid === 1'b1 && m.in_ready === 1'b1) begin
        q.push_back(ref16(m.a, m.b, m.cin, m.sub));
        acc++;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (q.size() != 0 || ret != acc) begin
      failures++;
      $display("FAIL bp_count got retired=%0d pending=%0d exp retired=%0d pending=0",
               ret, q.size(), acc);
    end
  endtask

  task automatic test_reset_midstream();
    m.out_ready = 1'b1;
    m.cin = 1'b0;
    m.sub = 1'b0;
    m.b   = 16'h1111;
    for (int c = 0; c < 5; c++) begin
      m.in_valid = (c < 4);
      m.a = 16'h1234 + 16'(c);
      tick();
    end
    checks++;
    if (m.out_valid !== 1'b1 || m.sum !== 16'h2345) begin
      failures++;
      $display("FAIL rst_pre got valid=%b sum=%h exp 1/2345", m.out_valid, m.sum);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (m.out_valid !== 1'b0 || m.sum !== 16'h0000 || m.cout !== 1'b0 || m.ovf !== 1'b0) begin
      failures++;
      $display("FAIL rst_async got valid=%b sum=%h cout=%b ovf=%b exp 0/0000/0/0",
               m.out_valid, m.sum, m.cout, m.ovf);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (m.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_stale cycle=%0d got valid=%b sum=%h exp 0", c, m.out_valid, m.sum);
      end
    end
    m.a = 16'h0102; m.b = 16'h0304; m.in_valid = 1'b1;
    tick();
    m.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (m.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_early_valid cycle=%0d got=%b exp=0", c, m.out_valid);
      end
      tick();
    end
    checks++;
    if (m.out_valid !== 1'b1 || m.sum !== 16'h0406 || m.cout !== 1'b0 || m.ovf !== 1'b0) begin
      failures++;
      $display("FAIL rst_first_result got valid=%b sum=%h cout=%b ovf=%b exp 1/0406/0/0",
               m.out_valid, m.sum, m.cout, m.ovf);
    end
    $display("rst_after a=0102 b=0304 sum=%h cout=%b ovf=%b", m.sum, m.cout, m.ovf);
  endtask

  initial begin
    m.in_valid = 1'b0; m.a = '0; m.b = '0; m.cin = 1'b0; m.sub = 1'b0; m.out_ready = 1'b1;
    n.in_valid = 1'b0; n.a = '0; n.b = '0; n.cin = 1'b0; n.sub = 1'b0; n.out_ready = 1'b1;
    w.in_valid = 1'b0; w.a = '0; w.b = '0; w.cin = 1'b0; w.sub = 1'b0; w.out_ready = 1'b1;
    test_reset();
    test_basic_add();
    test_add_sub_stream();
    test_stream_w8();
    test_stream_w32();
    test_backpressure();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
